ps2_kbd_rx: RTL and testbench
=============================

Name: ps2_kbd_rx

Overview:
PS/2 device-to-host receiver with a small byte FIFO. It sits directly upstream of the key decode/display logic.
- Samples the raw ps2_clk/ps2_data pins and deframes 11-bit frames.
- Checks start, parity and stop bits.
- Queues good scan-code bytes.
- Presents them to the consumer through a ready/nextdata_n handshake, with sticky overflow and frame-error reporting.

Parameters:
FIFO_DEPTH, 8, entry count; power of two, 2..64
TIMEOUT_CYCLES, 50000, clk cycles without a ps2_clk falling edge before a partial frame is discarded
ERR_CNT_W, 8, width of the frame error counter

Ports:
clk  in  1  system clock
rstn  in  1  reset, synchronous, active-low
ps2_clk  in  1  raw PS/2 clock pin, asynchronous
ps2_data  in  1  raw PS/2 data pin, asynchronous
data  out  8  FIFO head byte; valid only while ready=1
ready  out  1  FIFO non-empty
nextdata_n  in  1  active-low pop request, sampled each clk
overflow  out  1  sticky: a good frame was dropped because the FIFO was full
frame_err  out  1  one-cycle pulse: bad start, parity or stop bit
err_cnt  out  ERR_CNT_W  saturating count of bad frames

Behaviour:
Reset:
- Applies on the rstn=0 clock edge only.
- Clears the sync registers (to 1), bit counter, shift register, timeout counter, FIFO pointers and count.
- Outputs after reset: ready=0, overflow=0, frame_err=0, err_cnt=0, data=8'h00.
- Reset mid-frame discards the partial frame.

Synchronisation:
- ps2_clk and ps2_data each pass through 2 flops.
- A third flop on ps2_clk provides edge detect. fall = (s_prev==1 && s_cur==0).
- Data is sampled from the synchronised ps2_data in the fall cycle.

Frame FSM, states IDLE and RECV:
- IDLE: on fall with data==0 (start bit) -> RECV, bit_cnt=1. On fall with data==1 -> stay IDLE (glitch/idle, not an error).
- RECV, bit_cnt 1..8: shift data in LSB first. bit_cnt 9: capture parity. bit_cnt 10: capture stop, then evaluate and return to IDLE.
- Good frame = odd parity (^{data[7:0], parity}==1) and stop==1.
- Good frame: push on the same edge that samples stop; ready rises in the following cycle. Latency is 1 clk from the stop-bit fall cycle.
- Bad frame: no push; frame_err=1 for exactly 1 cycle; err_cnt+1, saturating at all-ones.
- Timeout: in RECV, a counter resets on every fall. At TIMEOUT_CYCLES -> IDLE, frame discarded, no frame_err.

FIFO and handshake:
- data = mem[rd_ptr], combinational from the registered pointer.
- ready = (count != 0).
- Pop occurs on any clk edge where nextdata_n==0 && ready==1; level semantics, one pop per cycle held low.
- nextdata_n==0 with ready==0: ignored.
- Push when full without a pop in the same cycle: byte dropped, overflow<=1.
- Push and pop in the same cycle: both performed and count unchanged, including when full (no overflow) and when count==1.
- Pointers wrap modulo FIFO_DEPTH.
- overflow clears on reset or on the first pop after it was set. A pop concurrent with a new overflow event leaves overflow=1.

Decomposition:
- Package ps2_pkg holds:
  - PS2_FRAME_BITS=11
  - PS2_EXT=8'hE0
  - PS2_BREAK=8'hF0
  - a typedef for the FSM state enum {IDLE, RECV}
- One sub-module, ps2_byte_fifo:
  - Parameters: DEPTH, width 8.
  - Ports: push/pop/din/dout/count/full/empty.
  - Synchronous active-low rstn.
- ps2_kbd_rx keeps the sync, FSM, timeout and error logic.

Test Plan:
- Drive 8'h1C (start 0, LSB-first data, parity 0, stop 1) at 10 kHz ps2_clk with nextdata_n=1 -> 1 clk after the stop fall, ready=1 and data=8'h1C; frame_err never pulses.
- Send F0,1C,E0 back-to-back, then pulse nextdata_n low 1 cycle three times -> data sequence F0,1C,E0; ready=0 after the third pop.
- Send 8'h45 with parity bit 1 (even) and then with stop=0 -> no push, ready=0; two single-cycle frame_err pulses; err_cnt=2.
- Send FIFO_DEPTH+1=9 bytes with no pops -> ready=1, first 8 bytes retained, 9th dropped, overflow=1. One pop -> overflow=0, data=2nd byte. Also push on the exact cycle of a pop while full -> no overflow, count stays 8.
- Send 5 bits of a frame, stall ps2_clk for TIMEOUT_CYCLES+10, then send a full 8'h16 -> only 16 received; err_cnt=0.
- Assert rstn=0 for 1 cycle mid-frame with 2 bytes queued -> ready=0, overflow=0, err_cnt=0. The next full frame 8'h29 is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receive path.
package ps2_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam logic [7:0]  PS2_EXT        = 8'hE0;
  localparam logic [7:0]  PS2_BREAK      = 8'hF0;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } ps2_state_t;

  // Odd parity over data plus parity bit: the XOR across all nine bits must be 1.
  function automatic logic ps2_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Consumer-side handshake between the PS/2 receiver and the key decode logic.
interface ps2_kbd_rx_if #(
  parameter int unsigned ERR_CNT_W = 8
) ();

  logic [7:0]           data;
  logic                 ready;
  logic                 nextdata_n;
  logic                 overflow;
  logic                 frame_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output data, ready, overflow, frame_err, err_cnt,
    input  nextdata_n
  );

  modport slave (
    input  data, ready, overflow, frame_err, err_cnt,
    output nextdata_n
  );

endinterface

// File: rtl/ps2_byte_fifo.sv
// Byte FIFO holding received scan codes; head byte is read combinationally.
module ps2_byte_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_wr;
  logic          w_rd;

  assign empty = (r_count == '0);
  assign full  = (r_count == (AW + 1)'(DEPTH));
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  assign w_rd = pop && !empty;
  assign w_wr = push && (!full || w_rd);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 device-to-host receiver: pin sync, 11-bit deframing, error reporting and byte queue.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned ERR_CNT_W      = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  ps2_kbd_rx_if.master bus
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] STOP_IDX = 4'(PS2_FRAME_BITS - 1);

  logic                  r_clk_s1, r_clk_s2, r_clk_s3;
  logic                  r_dat_s1, r_dat_s2;
  ps2_state_t            r_state;
  logic [3:0]            r_bit_cnt;
  logic [7:0]            r_shift;
  logic                  r_parity;
  logic [TO_W-1:0]       r_to_cnt;
  logic                  r_frame_err;
  logic [ERR_CNT_W-1:0]  r_err_cnt;
  logic                  r_overflow;

  logic                      w_fall;
  logic                      w_dat;
  logic                      w_stop_fall;
  logic                      w_good;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic [7:0]                w_dout;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_s3 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  assign w_fall      = r_clk_s3 && !r_clk_s2;
  assign w_dat       = r_dat_s2;
  assign w_stop_fall = (r_state == RECV) && w_fall && (r_bit_cnt == STOP_IDX);
  assign w_good      = ps2_parity_ok(r_shift, r_parity) && w_dat;
  assign w_push      = w_stop_fall && w_good;
  assign w_pop       = !bus.nextdata_n && !w_empty;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_to_cnt <= '0;
          if (w_fall && !w_dat) begin
            r_state   <= RECV;
            r_bit_cnt <= 4'd1;
          end
        end
        RECV: begin
          if (w_fall) begin
            r_to_cnt  <= '0;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt <= 4'd8) begin
              r_shift <= {w_dat, r_shift[7:1]};
            end else if (r_bit_cnt == 4'd9) begin
              r_parity <= w_dat;
            end else begin
              r_state   <= IDLE;
              r_bit_cnt <= '0;
            end
          end else if (r_to_cnt == TO_LAST) begin
            // Device stalled mid-frame: drop the partial frame silently.
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_bit_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_frame_err <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_frame_err <= w_stop_fall && !w_good;
      if (w_stop_fall && !w_good && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  // A push that coincides with a pop is never an overflow, so only a clean pop clears the flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end else if (w_pop) begin
      r_overflow <= 1'b0;
    end
  end

  ps2_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (w_push),
    .pop   (w_pop),
    .din   (r_shift),
    .dout  (w_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign bus.data      = w_dout;
  assign bus.ready     = (w_count != '0);
  assign bus.overflow  = r_overflow;
  assign bus.frame_err = r_frame_err;
  assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: directed PS/2 frames, popped bytes checked against a queue.
`timescale 1ns/1ns
module tb_ps2_kbd_rx;
  import ps2_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TO    = 200;
  localparam int unsigned HALF  = 20;  // 40 clk per PS/2 bit at 400 kHz clk gives 10 kHz

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_kbd_rx_if #(.ERR_CNT_W(8)) bus ();

  ps2_kbd_rx #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO),
    .ERR_CNT_W      (8)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  always #1250 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int fe_pulses = 0;
  logic fe_prev = 1'b0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: frame_err must be single-cycle; every pop is compared to the scoreboard head.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rstn) begin
      if (bus.frame_err) begin
        if (!fe_prev) fe_pulses++;
        chk("frame_err_width", 32'(fe_prev), 32'd0);
      end
      fe_prev = bus.frame_err;
      if (bus.ready && !bus.nextdata_n) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected actual=%0h expected=none at %0t", bus.data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", 32'(bus.data), 32'(e));
        end
      end
    end else begin
      fe_prev = 1'b0;
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop,
                            input int unsigned nbits, input bit chk_lat, input bit pop_sync);
    logic [10:0] f;
    f = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int unsigned i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (HALF) tick();
      ps2_clk = 1'b0;
      if (i == 10) begin
        @(posedge clk);
        @(posedge clk);
        #1;
        if (pop_sync) bus.nextdata_n = 1'b0;
        if (chk_lat) begin
          @(negedge clk);
          chk("latency_pre_ready", 32'(bus.ready), 32'd0);
        end
        @(posedge clk);
        #1;
        if (pop_sync) bus.nextdata_n = 1'b1;
        if (chk_lat) begin
          @(negedge clk);
          chk("latency_ready", 32'(bus.ready), 32'd1);
          chk("latency_data", 32'(bus.data), 32'(b));
        end
        repeat (HALF - 3) tick();
      end else begin
        repeat (HALF) tick();
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF) tick();
  endtask

  task automatic good(input logic [7:0] b);
    exp_q.push_back(b);
    send_frame(b, 1'b0, 1'b1, 11, 1'b0, 1'b0);
  endtask

  task automatic pop1();
    bus.nextdata_n = 1'b0;
    tick();
    bus.nextdata_n = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    tick();
    rstn = 1'b0;
    exp_q.delete();
    tick();
    rstn = 1'b1;
  endtask

  task automatic sample(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, act, exp);
  endtask

  logic [7:0] ovf_bytes [9] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};

  initial begin
    bus.nextdata_n = 1'b1;
    repeat (3) tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("rst_data", 32'(bus.data), 32'd0);
    tick();

    // Single frame with exact push latency
    fe_pulses = 0;
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b1, 1'b0);
    chk("t1_no_frame_err", 32'(fe_pulses), 32'd0);
    pop1();

    // Back-to-back frames, drained in order
    good(PS2_BREAK);
    good(8'h1C);
    good(PS2_EXT);
    pop1();
    pop1();
    pop1();
    @(negedge clk);
    chk("t2_ready_after_drain", 32'(bus.ready), 32'd0);
    tick();

    // Bad parity, then bad stop
    fe_pulses = 0;
    send_frame(8'h45, 1'b1, 1'b1, 11, 1'b0, 1'b0);
    send_frame(8'h45, 1'b0, 1'b0, 11, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_ready", 32'(bus.ready), 32'd0);
    chk("t3_err_pulses", 32'(fe_pulses), 32'd2);
    chk("t3_err_cnt", 32'(bus.err_cnt), 32'd2);
    tick();

    // Overflow and push-during-pop while full
    do_reset();
    fe_pulses = 0;
    for (int i = 0; i < 9; i++) begin
      if (i < int'(DEPTH)) exp_q.push_back(ovf_bytes[i]);
      send_frame(ovf_bytes[i], 1'b0, 1'b1, 11, 1'b0, 1'b0);
    end
    @(negedge clk);
    chk("t4_ready_full", 32'(bus.ready), 32'd1);
    chk("t4_overflow_set", 32'(bus.overflow), 32'd1);
    tick();
    pop1();
    @(negedge clk);
    chk("t4_overflow_clr", 32'(bus.overflow), 32'd0);
    chk("t4_head_2nd", 32'(bus.data), 32'h22);
    tick();
    good(8'hAA);
    exp_q.push_back(8'hBB);
    send_frame(8'hBB, 1'b0, 1'b1, 11, 1'b0, 1'b1);
    @(negedge clk);
    chk("t4_no_ovf_on_pushpop", 32'(bus.overflow), 32'd0);
    tick();
    for (int i = 0; i < 7; i++) pop1();
    @(negedge clk);
    chk("t4_count8_ready", 32'(bus.ready), 32'd1);
    tick();
    pop1();
    @(negedge clk);
    chk("t4_count8_empty", 32'(bus.ready), 32'd0);
    tick();

    // Partial frame abandoned by timeout
    send_frame(8'h5C, 1'b0, 1'b1, 5, 1'b0, 1'b0);
    repeat (TO + 10) tick();
    good(8'h16);
    @(negedge clk);
    chk("t5_ready", 32'(bus.ready), 32'd1);
    chk("t5_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("t5_err_pulses", 32'(fe_pulses), 32'd0);
    tick();
    pop1();
    @(negedge clk);
    chk("t5_empty", 32'(bus.ready), 32'd0);
    tick();

    // Reset mid-frame with bytes queued and an error counted
    send_frame(8'h3A, 1'b0, 1'b0, 11, 1'b0, 1'b0);
    good(8'h3A);
    good(8'h4B);
    @(negedge clk);
    chk("t6_err_before", 32'(bus.err_cnt), 32'd1);
    tick();
    send_frame(8'h5C, 1'b0, 1'b1, 5, 1'b0, 1'b0);
    do_reset();
    @(negedge clk);
    chk("t6_ready", 32'(bus.ready), 32'd0);
    chk("t6_overflow", 32'(bus.overflow), 32'd0);
    chk("t6_err_cnt", 32'(bus.err_cnt), 32'd0);
    tick();
    good(8'h29);
    @(negedge clk);
    chk("t6_ready_after", 32'(bus.ready), 32'd1);
    tick();
    pop1();
    @(negedge clk);
    chk("t6_empty", 32'(bus.ready), 32'd0);
    chk("t6_err_final", 32'(bus.err_cnt), 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
